// File: rtl/alu_muldiv_seq.sv
// Sequential RV32M-style multiply/divide unit of width N.
// One product or quotient bit is produced per cycle in CALC. Sign fix-up and
// result selection happen in FIX. Divide-by-zero and signed overflow bypass CALC.
module alu_muldiv_seq #(
    parameter int N = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic [2:0]   FUNCT3,
    input  logic [N-1:0] RS1_DATA,
    input  logic [N-1:0] RS2_DATA,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] RESULT,
    output logic [3:0]   FLAG_REG
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;

    // Operation context captured on accept
    logic [2:0]       op_r;
    logic             neg_a_r;
    logic             neg_b_r;
    logic             fast_r;
    logic             ovf_r;
    logic             dz_r;
    logic [CW-1:0]    count_r;
    // MUL: {partial high, multiplier}; DIV: {partial remainder, dividend/quotient}
    logic [2*N-1:0]   prod_r;
    // Multiplicand (MUL) or divisor magnitude (DIV)
    logic [N-1:0]     opnd_r;

    logic             busy_r;
    logic             done_r;
    logic [N-1:0]     result_r;
    logic [3:0]       flag_r;

    // Accept-side decode
    logic             accept_s;
    logic             a_signed_s;
    logic             b_signed_s;
    logic             neg_a_in_s;
    logic             neg_b_in_s;
    logic [N-1:0]     mag_a_s;
    logic [N-1:0]     mag_b_s;
    logic             dz_in_s;
    logic             ovf_in_s;
    logic [N-1:0]     fast_val_s;

    // Iteration datapath
    logic             last_iter_s;
    logic [N:0]       mul_sum_s;
    logic [2*N-1:0]   mul_next_s;
    logic [N:0]       rem_shift_s;
    logic             rem_ge_s;
    logic [N-1:0]     rem_diff_s;
    logic [2*N-1:0]   div_next_s;

    // Fix-up datapath
    logic [2*N-1:0]   prod_signed_s;
    logic [N-1:0]     quot_s;
    logic [N-1:0]     rem_s;
    logic [N-1:0]     final_s;
    logic [3:0]       flags_s;

    assign accept_s    = START && (state_r == IDLE);
    assign last_iter_s = (count_r == CW'(N - 1));

    // Decode operand signedness, magnitudes and fast-path conditions of the incoming op
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        fast_val_s = {N{1'b0}};
        case (FUNCT3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            3'b010: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        neg_a_in_s = a_signed_s && RS1_DATA[N-1];
        neg_b_in_s = b_signed_s && RS2_DATA[N-1];
        if (neg_a_in_s) begin
            mag_a_s = {N{1'b0}} - RS1_DATA;
        end else begin
            mag_a_s = RS1_DATA;
        end
        if (neg_b_in_s) begin
            mag_b_s = {N{1'b0}} - RS2_DATA;
        end else begin
            mag_b_s = RS2_DATA;
        end
        dz_in_s  = FUNCT3[2] && (RS2_DATA == {N{1'b0}});
        ovf_in_s = ((FUNCT3 == 3'b100) || (FUNCT3 == 3'b110)) &&
                   (RS1_DATA == {1'b1, {(N-1){1'b0}}}) &&
                   (RS2_DATA == {N{1'b1}});
        case (FUNCT3)
            3'b100, 3'b101: begin
                if (dz_in_s) begin
                    fast_val_s = {N{1'b1}};
                end else begin
                    fast_val_s = RS1_DATA;
                end
            end
            3'b110, 3'b111: begin
                if (dz_in_s) begin
                    fast_val_s = RS1_DATA;
                end else begin
                    fast_val_s = {N{1'b0}};
                end
            end
            default: fast_val_s = {N{1'b0}};
        endcase
    end

    // One shift-add multiply step and one restoring-divide step
    always_comb begin
        if (prod_r[0]) begin
            mul_sum_s = {1'b0, prod_r[2*N-1:N]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, prod_r[2*N-1:N]};
        end
        mul_next_s  = {mul_sum_s, prod_r[N-1:1]};
        rem_shift_s = {prod_r[2*N-1:N], prod_r[N-1]};
        rem_ge_s    = (rem_shift_s >= {1'b0, opnd_r});
        rem_diff_s  = rem_shift_s[N-1:0] - opnd_r;
        if (rem_ge_s) begin
            div_next_s = {rem_diff_s, prod_r[N-2:0], 1'b1};
        end else begin
            div_next_s = {prod_r[2*N-2:0], 1'b0};
        end
    end

    // Apply result signs, pick the requested half/quotient/remainder and form flags
    always_comb begin
        if (neg_a_r ^ neg_b_r) begin
            prod_signed_s = {(2*N){1'b0}} - prod_r;
            quot_s        = {N{1'b0}} - prod_r[N-1:0];
        end else begin
            prod_signed_s = prod_r;
            quot_s        = prod_r[N-1:0];
        end
        if (neg_a_r) begin
            rem_s = {N{1'b0}} - prod_r[2*N-1:N];
        end else begin
            rem_s = prod_r[2*N-1:N];
        end
        if (fast_r) begin
            final_s = prod_r[N-1:0];
        end else begin
            case (op_r)
                3'b000:                 final_s = prod_signed_s[N-1:0];
                3'b001, 3'b010, 3'b011: final_s = prod_signed_s[2*N-1:N];
                3'b100, 3'b101:         final_s = quot_s;
                3'b110, 3'b111:         final_s = rem_s;
                default:                final_s = {N{1'b0}};
            endcase
        end
        flags_s = {ovf_r, dz_r, final_s[N-1], (final_s == {N{1'b0}})};
    end

    // Next-state logic: IDLE -> CALC -> FIX -> IDLE, or IDLE -> FIX on fast paths
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (dz_in_s || ovf_in_s) begin
                        state_next_s = FIX;
                    end else begin
                        state_next_s = CALC;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (last_iter_s) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = CALC;
                end
            end
            FIX:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register and registered BUSY
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Operand capture, iteration registers and completion outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_r     <= 3'b000;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            fast_r   <= 1'b0;
            ovf_r    <= 1'b0;
            dz_r     <= 1'b0;
            count_r  <= {CW{1'b0}};
            prod_r   <= {(2*N){1'b0}};
            opnd_r   <= {N{1'b0}};
            done_r   <= 1'b0;
            result_r <= {N{1'b0}};
            flag_r   <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        op_r    <= FUNCT3;
                        neg_a_r <= neg_a_in_s;
                        neg_b_r <= neg_b_in_s;
                        fast_r  <= dz_in_s || ovf_in_s;
                        ovf_r   <= ovf_in_s;
                        dz_r    <= dz_in_s;
                        count_r <= {CW{1'b0}};
                        if (dz_in_s || ovf_in_s) begin
                            prod_r <= {{N{1'b0}}, fast_val_s};
                            opnd_r <= {N{1'b0}};
                        end else if (FUNCT3[2]) begin
                            prod_r <= {{N{1'b0}}, mag_a_s};
                            opnd_r <= mag_b_s;
                        end else begin
                            prod_r <= {{N{1'b0}}, mag_b_s};
                            opnd_r <= mag_a_s;
                        end
                    end
                end
                CALC: begin
                    done_r  <= 1'b0;
                    count_r <= count_r + CW'(1);
                    if (op_r[2]) begin
                        prod_r <= div_next_s;
                    end else begin
                        prod_r <= mul_next_s;
                    end
                end
                FIX: begin
                    done_r   <= 1'b1;
                    result_r <= final_s;
                    flag_r   <= flags_s;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY     = busy_r;
    assign DONE     = done_r;
    assign RESULT   = result_r;
    assign FLAG_REG = flag_r;

endmodule
